// File: rtl/stream_mux.sv
// N-way valid/ready stream multiplexer with explicit-select or round-robin grant and a registered output.
// Optional MUX_SKID_EN adds a one-entry skid buffer so inReady depends only on registered state.
module stream_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N*WIDTH-1:0] inData,
  input  logic [N-1:0]       inValid,
  output logic [N-1:0]       inReady,
  input  logic [SELW-1:0]    sel,
  input  logic               rrMode,
  output logic [WIDTH-1:0]   outData,
  output logic [SELW-1:0]    outSel,
  output logic               outValid,
  input  logic               outReady
);

  logic [SELW-1:0]  rr_ptr;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             accept;
  logic             in_xfer;
  logic             out_xfer;
  int               rr_idx;

  // Round-robin scans downward in distance so the nearest valid channel after rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    if (!rrMode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && inValid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        rr_idx = int'(rr_ptr) + k;
        if (rr_idx >= N) rr_idx = rr_idx - N;
        if (inValid[rr_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(rr_idx);
        end
      end
    end
  end

  assign grant_data = inData[int'(grant_idx)*WIDTH +: WIDTH];

`ifdef MUX_SKID_EN
  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  logic [SELW-1:0]  skid_sel;

  assign accept = ~skid_full;
`else
  assign accept = ~outValid | outReady;
`endif

  assign in_xfer  = grant_valid & accept & ~rst_i;
  assign out_xfer = outValid & outReady;

  always_comb begin
    inReady = '0;
    for (int i = 0; i < N; i++) begin
      if (in_xfer && grant_idx == SELW'(i)) inReady[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= SELW'(N-1);
    end else if (in_xfer && rrMode) begin
      rr_ptr <= grant_idx;
    end
  end

`ifdef MUX_SKID_EN
  // A full skid entry blocks input, so it only ever drains into the output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outValid  <= 1'b0;
      outData   <= '0;
      outSel    <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else if (skid_full) begin
      if (out_xfer) begin
        outData   <= skid_data;
        outSel    <= skid_sel;
        outValid  <= 1'b1;
        skid_full <= 1'b0;
      end
    end else if (in_xfer) begin
      if (outValid && !outReady) begin
        skid_data <= grant_data;
        skid_sel  <= grant_idx;
        skid_full <= 1'b1;
      end else begin
        outData  <= grant_data;
        outSel   <= grant_idx;
        outValid <= 1'b1;
      end
    end else if (out_xfer) begin
      outValid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outValid <= 1'b0;
      outData  <= '0;
      outSel   <= '0;
    end else if (in_xfer) begin
      outData  <= grant_data;
      outSel   <= grant_idx;
      outValid <= 1'b1;
    end else if (out_xfer) begin
      outValid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux: a 4-channel instance for the main traffic and a 3-channel
// instance for out-of-range select.
module tb_stream_mux;

  logic        clk;
  logic        rst_i;
  logic [127:0] inData;
  logic [3:0]  inValid;
  logic [3:0]  inReady;
  logic [1:0]  sel;
  logic        rrMode;
  logic [31:0] outData;
  logic [1:0]  outSel;
  logic        outValid;
  logic        outReady;

  logic [95:0] inData3;
  logic [2:0]  inValid3;
  logic [2:0]  inReady3;
  logic [1:0]  sel3;
  logic [31:0] outData3;
  logic [1:0]  outSel3;
  logic        outValid3;
  logic        outReady3;

  int checks = 0;
  int errors = 0;
  int step   = 0;
  bit beef   = 0;
  logic [33:0] sb[$];
  logic [31:0] hold_data;

  stream_mux #(.WIDTH(32), .N(4), .SELW(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .inData(inData), .inValid(inValid), .inReady(inReady),
    .sel(sel), .rrMode(rrMode), .outData(outData), .outSel(outSel), .outValid(outValid),
    .outReady(outReady)
  );

  stream_mux #(.WIDTH(32), .N(3), .SELW(2)) dut3 (
    .clk_i(clk), .rst_i(rst_i), .inData(inData3), .inValid(inValid3), .inReady(inReady3),
    .sel(sel3), .rrMode(1'b0), .outData(outData3), .outSel(outSel3), .outValid(outValid3),
    .outReady(outReady3)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(int ch);
    if (beef && ch == 2) return 32'hDEADBEEF;
    return 32'h1000_0000 * (ch + 1) + step;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (step %0d)", name, actual, expected, step);
    end
  endtask

  // Drives one cycle's inputs and predicts which channel (if any) transfers this cycle.
  task automatic apply_stimulus(input logic [3:0] v, input logic [1:0] s, input logic rr,
                                input logic ordy, input logic [3:0] exp_rdy);
    @(posedge clk);
    #1;
    step++;
    inValid  = v;
    sel      = s;
    rrMode   = rr;
    outReady = ordy;
    for (int i = 0; i < 4; i++) inData[i*32 +: 32] = word_of(i);
    #1;
    check_output("in_ready", {60'd0, inReady}, {60'd0, exp_rdy});
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) sb.push_back({word_of(i), 2'(i)});
    end
  endtask

  // Every output transfer must match the oldest predicted word.
  initial begin
    logic [33:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_i && outValid && outReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out: got %0h/%0d expected none", outData, outSel);
        end else begin
          exp = sb.pop_front();
          check_output("out_data", {32'd0, outData}, {32'd0, exp[33:2]});
          check_output("out_sel", {62'd0, outSel}, {62'd0, exp[1:0]});
        end
      end
    end
  end

  initial begin
    rst_i = 1; inValid = 4'hF; sel = 0; rrMode = 1; outReady = 1; inData = '0;
    inData3 = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
    inValid3 = 0; sel3 = 0; outReady3 = 0;
    repeat (3) @(posedge clk);
    #2;
    check_output("rst_out_valid", {63'd0, outValid}, 64'd0);
    check_output("rst_out_data", {32'd0, outData}, 64'd0);
    check_output("rst_out_sel", {62'd0, outSel}, 64'd0);
    check_output("rst_in_ready", {60'd0, inReady}, 64'd0);
    @(posedge clk);
    #1 inValid = 0; rst_i = 0;

    // Explicit select, then a select whose channel is not valid
    beef = 1;
    apply_stimulus(4'b0100, 2'd2, 1'b0, 1'b1, 4'b0100);
    beef = 0;
    apply_stimulus(4'b1011, 2'd2, 1'b0, 1'b1, 4'b0000);

    // Round-robin over all four channels, then over channels 1 and 3
    for (int k = 0; k < 8; k++)
      apply_stimulus(4'hF, 2'd0, 1'b1, 1'b1, 4'(1 << (k % 4)));
    for (int k = 0; k < 4; k++)
      apply_stimulus(4'b1010, 2'd0, 1'b1, 1'b1, (k % 2 == 0) ? 4'b0010 : 4'b1000);

    // Backpressure with the output register holding a ch0 word
    apply_stimulus(4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001);
    hold_data = word_of(0);
    for (int k = 0; k < 3; k++) begin
`ifdef MUX_SKID_EN
      apply_stimulus(4'b0001, 2'd0, 1'b0, 1'b0, (k == 0) ? 4'b0001 : 4'b0000);
`else
      apply_stimulus(4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000);
`endif
      check_output("stall_data", {32'd0, outData}, {32'd0, hold_data});
      check_output("stall_sel", {62'd0, outSel}, 64'd0);
      check_output("stall_valid", {63'd0, outValid}, 64'd1);
    end
`ifdef MUX_SKID_EN
    apply_stimulus(4'b0001, 2'd0, 1'b0, 1'b1, 4'b0000);
`endif
    apply_stimulus(4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001);

    // Full throughput on ch0, then a mid-stream switch to ch3
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(4'b1001, 2'd0, 1'b0, 1'b1, 4'b0001);
      check_output("tput_valid", {63'd0, outValid}, 64'd1);
    end
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(4'b1001, 2'd3, 1'b0, 1'b1, 4'b1000);
      check_output("tput_valid", {63'd0, outValid}, 64'd1);
    end

    // Reset mid-stream discards the held word
    @(posedge clk);
    #1 rst_i = 1; outReady = 0; inValid = 4'hF; rrMode = 1;
    #1;
    check_output("mid_rst_valid", {63'd0, outValid}, 64'd0);
    check_output("mid_rst_data", {32'd0, outData}, 64'd0);
    check_output("mid_rst_sel", {62'd0, outSel}, 64'd0);
    check_output("mid_rst_ready", {60'd0, inReady}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1 inValid = 0; rst_i = 0;
    apply_stimulus(4'hF, 2'd0, 1'b1, 1'b1, 4'b0001);
    apply_stimulus(4'hF, 2'd0, 1'b1, 1'b1, 4'b0010);

    // Drain; everything predicted must have emerged
    for (int k = 0; k < 4; k++)
      apply_stimulus(4'b0000, 2'd0, 1'b0, 1'b1, 4'b0000);
    check_output("sb_empty", 64'(sb.size()), 64'd0);
    check_output("drained_valid", {63'd0, outValid}, 64'd0);

    // Out-of-range select on the 3-channel instance
    @(posedge clk);
    #1 inValid3 = 3'b111; sel3 = 2'd0; outReady3 = 0;
    #1 check_output("oor_first_ready", {61'd0, inReady3}, 64'd1);
    @(posedge clk);
    #1 sel3 = 2'd3;
    #1;
    check_output("oor_ready_stall", {61'd0, inReady3}, 64'd0);
    check_output("oor_valid", {63'd0, outValid3}, 64'd1);
    check_output("oor_data", {32'd0, outData3}, 64'h3000_0000);
    check_output("oor_sel", {62'd0, outSel3}, 64'd0);
    @(posedge clk);
    #1 outReady3 = 1;
    #1 check_output("oor_ready_open", {61'd0, inReady3}, 64'd0);
    @(posedge clk);
    #2;
    check_output("oor_drained", {63'd0, outValid3}, 64'd0);
    check_output("oor_ready_idle", {61'd0, inReady3}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
